// File: rtl/conv_coprocessor_param.sv
// 1-D convolution coprocessor: Z[i] = sum_j H[i-j]*Y[j] with loadable taps and a saturated output.
// Define CONV_COPROC_SIGNED_EN for two's-complement arithmetic; the default build is unsigned.
module conv_coprocessor_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_Y  = 32,
  parameter int unsigned MAX_H  = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [$clog2(MAX_Y+1)-1:0]         sizeY,
  input  logic [$clog2(MAX_H+1)-1:0]         sizeH,
  input  logic                               h_wr_en,
  input  logic [$clog2(MAX_H)-1:0]           h_wr_addr,
  input  logic [DATA_W-1:0]                  h_wr_data,
  output logic [$clog2(MAX_Y)-1:0]           memY_addr,
  input  logic [DATA_W-1:0]                  dataY,
  output logic [OUT_W-1:0]                   dataZ,
  output logic [$clog2(MAX_Y+MAX_H-1)-1:0]   memZ_addr,
  output logic                               writeZ,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int unsigned YSW = $clog2(MAX_Y + 1);
  localparam int unsigned HSW = $clog2(MAX_H + 1);
  localparam int unsigned HAW = $clog2(MAX_H);
  localparam int unsigned YAW = $clog2(MAX_Y);
  localparam int unsigned ZAW = $clog2(MAX_Y + MAX_H - 1);
  localparam int unsigned ZSW = ZAW + 1;

  typedef enum logic [2:0] {StIdle, StErr, StClear, StMac, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ZAW-1:0]    i_q, i_d;
  logic [YAW-1:0]    j_q, j_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [YSW-1:0]    size_y_q, size_y_d;
  logic [HSW-1:0]    size_h_q, size_h_d;
  logic [ZSW-1:0]    size_z_q, size_z_d;
  logic [DATA_W-1:0] tap_q [MAX_H];
  logic [DATA_W-1:0] tap_d [MAX_H];
  logic [YAW-1:0]    mem_y_addr_q, mem_y_addr_d;
  logic [OUT_W-1:0]  data_z_q, data_z_d;
  logic [ZAW-1:0]    mem_z_addr_q, mem_z_addr_d;
  logic              write_z_q, write_z_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ZAW+1:0]    k;
  logic              tap_hit;
  logic [DATA_W-1:0] tap_sel;
  logic [ACC_W-1:0]  op_h, op_y, prod;
  logic              sizes_ok;

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] a);
`ifdef CONV_COPROC_SIGNED_EN
    // In range only when every bit from the output sign upward matches.
    logic [ACC_W-OUT_W:0] top;
    top = a[ACC_W-1:OUT_W-1];
    if ((&top) || !(|top)) return a[OUT_W-1:0];
    else if (a[ACC_W-1])   return {1'b1, {(OUT_W-1){1'b0}}};
    else                   return {1'b0, {(OUT_W-1){1'b1}}};
`else
    if (|a[ACC_W-1:OUT_W]) return {OUT_W{1'b1}};
    else                   return a[OUT_W-1:0];
`endif
  endfunction

  always_comb begin
    // k = i - j as a two's-complement value; negative means the tap index is out of range.
    k       = (ZAW+2)'(i_q) - (ZAW+2)'(j_q);
    tap_hit = !k[ZAW+1] && (k < (ZAW+2)'(size_h_q));
    tap_sel = tap_q[k[HAW-1:0]];
`ifdef CONV_COPROC_SIGNED_EN
    op_h = {{(ACC_W-DATA_W){tap_sel[DATA_W-1]}}, tap_sel};
    op_y = {{(ACC_W-DATA_W){dataY[DATA_W-1]}}, dataY};
`else
    op_h = {{(ACC_W-DATA_W){1'b0}}, tap_sel};
    op_y = {{(ACC_W-DATA_W){1'b0}}, dataY};
`endif
    prod     = op_h * op_y;
    sizes_ok = (sizeY != '0) && (32'(sizeY) <= MAX_Y) && (sizeH != '0) && (32'(sizeH) <= MAX_H);
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    acc_d        = acc_q;
    size_y_d     = size_y_q;
    size_h_d     = size_h_q;
    size_z_d     = size_z_q;
    tap_d        = tap_q;
    data_z_d     = data_z_q;
    mem_z_addr_d = mem_z_addr_q;

    unique case (state_q)
      StIdle: begin
        if (h_wr_en) tap_d[h_wr_addr] = h_wr_data;
        if (start) begin
          if (sizes_ok) begin
            size_y_d = sizeY;
            size_h_d = sizeH;
            size_z_d = ZSW'(sizeY) + ZSW'(sizeH) - ZSW'(1);
            i_d      = '0;
            state_d  = StClear;
          end else begin
            state_d = StErr;
          end
        end
      end
      StErr:   state_d = StIdle;
      StClear: begin
        acc_d   = '0;
        j_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        if (tap_hit) acc_d = acc_q + prod;
        j_d = j_q + YAW'(1);
        if (YSW'(j_q) == size_y_q - YSW'(1)) begin
          state_d      = StWrite;
          mem_z_addr_d = i_q;
          data_z_d     = sat(acc_d);
        end
      end
      StWrite: begin
        if (ZSW'(i_q) == size_z_q - ZSW'(1)) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + ZAW'(1);
          state_d = StClear;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so decode them from the next state.
    busy_d       = (state_d == StClear) || (state_d == StMac) || (state_d == StWrite);
    done_d       = (state_d == StDone) || (state_d == StErr);
    err_d        = (state_d == StErr);
    write_z_d    = (state_d == StWrite);
    mem_y_addr_d = (state_d == StMac) ? j_d : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      i_q          <= '0;
      j_q          <= '0;
      acc_q        <= '0;
      size_y_q     <= '0;
      size_h_q     <= '0;
      size_z_q     <= '0;
      for (int n = 0; n < MAX_H; n++) tap_q[n] <= '0;
      mem_y_addr_q <= '0;
      data_z_q     <= '0;
      mem_z_addr_q <= '0;
      write_z_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      acc_q        <= acc_d;
      size_y_q     <= size_y_d;
      size_h_q     <= size_h_d;
      size_z_q     <= size_z_d;
      for (int n = 0; n < MAX_H; n++) tap_q[n] <= tap_d[n];
      mem_y_addr_q <= mem_y_addr_d;
      data_z_q     <= data_z_d;
      mem_z_addr_q <= mem_z_addr_d;
      write_z_q    <= write_z_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign memY_addr = mem_y_addr_q;
  assign dataZ     = data_z_q;
  assign memZ_addr = mem_z_addr_q;
  assign writeZ    = write_z_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_coprocessor_param.sv
// Self-checking bench for conv_coprocessor_param: a direct-sum convolution model feeds an expected
// write queue that a per-cycle monitor checks; literal values pin the model.
module tb_conv_coprocessor_param;
  localparam int DW = 8;
  localparam int MY = 32;
  localparam int MH = 8;
  localparam int AW = 20;
  localparam int OW = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [5:0] sizeY = '0;
  logic [3:0] sizeH = '0;
  logic       h_wr_en = 1'b0;
  logic [2:0] h_wr_addr = '0;
  logic [7:0] h_wr_data = '0;
  logic [4:0] memY_addr;
  logic [7:0] dataY;
  logic [15:0] dataZ;
  logic [5:0] memZ_addr;
  logic       writeZ, busy, done, err;

  logic [7:0] ymem [MY];
  logic [7:0] h_model [MH];
  int exp_addr_q[$];
  int exp_data_q[$];
  int got [64];
  int checks = 0;
  int errors = 0;

  assign dataY = ymem[memY_addr];

  conv_coprocessor_param #(
    .DATA_W(DW), .MAX_Y(MY), .MAX_H(MH), .ACC_W(AW), .OUT_W(OW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .sizeY(sizeY), .sizeH(sizeH),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .memY_addr(memY_addr), .dataY(dataY), .dataZ(dataZ), .memZ_addr(memZ_addr),
    .writeZ(writeZ), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int sat_model(input int v);
`ifdef CONV_COPROC_SIGNED_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v & 32'hFFFF;
`else
    return (v > 65535) ? 65535 : v;
`endif
  endfunction

  function automatic int val8(input logic [7:0] x);
`ifdef CONV_COPROC_SIGNED_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  task automatic build_expect(input int sy, input int sh);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < sy + sh - 1; i++) begin
      int s;
      s = 0;
      for (int j = 0; j < sy; j++)
        if (i - j >= 0 && i - j < sh) s += val8(h_model[i-j]) * val8(ymem[j]);
      exp_addr_q.push_back(i);
      exp_data_q.push_back(sat_model(s));
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (writeZ) begin
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_writeZ: addr %0d data %0d with no write expected",
                   memZ_addr, dataZ);
        end else begin
          chk("z_addr", int'(memZ_addr), exp_addr_q[0]);
          chk("z_data", int'(dataZ), exp_data_q[0]);
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
          got[memZ_addr] = int'(dataZ);
        end
      end
      chk("done_busy_exclusive", int'(done & busy), 0);
    end
  end

  task automatic write_tap(input int addr, input int val);
    h_wr_en = 1'b1;
    h_wr_addr = 3'(addr);
    h_wr_data = 8'(val);
    @(posedge clk); #1;
    h_wr_en = 1'b0;
    h_model[addr] = 8'(val);
  endtask

  task automatic run_op(input int sy, input int sh, input bit exp_err, input int abort_at,
                        input bit disturb);
    int n, busy_cnt, lat;
    for (int a = 0; a < 64; a++) got[a] = -1;
    if (exp_err) begin
      exp_addr_q.delete();
      exp_data_q.delete();
    end else begin
      build_expect(sy, sh);
    end
    sizeY = 6'(sy);
    sizeH = 4'(sh);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (!done && n < 400) begin
      if (busy) busy_cnt++;
      if (disturb && n == 5) begin
        start = 1'b1;
        h_wr_en = 1'b1;
        h_wr_addr = 3'd0;
        h_wr_data = 8'd99;
      end
      if (disturb && n == 7) begin
        start = 1'b0;
        h_wr_en = 1'b0;
      end
      if (abort_at == n) begin
        rstn = 1'b0;
        #2;
        chk("rst_writeZ", int'(writeZ), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_dataZ", int'(dataZ), 0);
        chk("rst_memZ_addr", int'(memZ_addr), 0);
        chk("rst_memY_addr", int'(memY_addr), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int t = 0; t < MH; t++) h_model[t] = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    lat = exp_err ? 1 : (sy + sh - 1) * (sy + 2) + 1;
    chk("done_latency", n, lat);
    chk("done_err", int'(err), int'(exp_err));
    chk("busy_cycles", busy_cnt, lat - 1);
    @(posedge clk); #1;
    chk("done_pulse_width", int'(done), 0);
    chk("z_writes_outstanding", exp_addr_q.size(), 0);
  endtask

  task automatic load_basic();
    ymem[0] = 8'd1; ymem[1] = 8'd2; ymem[2] = 8'd3;
    for (int t = 0; t < 3; t++) write_tap(t, 1);
  endtask

  task automatic check_basic_got(input string tag);
    int lit [5];
    lit = '{1, 3, 6, 5, 3};
    for (int a = 0; a < 5; a++) chk(tag, got[a], lit[a]);
  endtask

  initial begin
    int dcnt;
    for (int a = 0; a < MY; a++) ymem[a] = '0;
    for (int t = 0; t < MH; t++) h_model[t] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_writeZ", int'(writeZ), 0);
    chk("reset_dataZ", int'(dataZ), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic convolution
    load_basic();
    build_expect(3, 3);
    chk("model_basic_z2", exp_data_q[2], 6);
    chk("model_basic_z3", exp_data_q[3], 5);
    run_op(3, 3, 1'b0, 0, 1'b0);
    check_basic_got("basic_z");

    // Rejected sizes
    run_op(0, 3, 1'b1, 0, 1'b0);
    run_op(3, 9, 1'b1, 0, 1'b0);
    run_op(33, 3, 1'b1, 0, 1'b0);
    run_op(3, 0, 1'b1, 0, 1'b0);

    // Boundary sizes: single-tap, single-sample
    run_op(1, 1, 1'b0, 0, 1'b0);
    chk("size1_z0", got[0], 1);

    // Start and tap write during busy are ignored
    run_op(3, 3, 1'b0, 0, 1'b1);
    check_basic_got("protocol_z");
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("protocol_extra_done", dcnt, 0);
    run_op(3, 3, 1'b0, 0, 1'b0);
    check_basic_got("protocol_tap0_kept");

    // Saturation
    for (int a = 0; a < 4; a++) ymem[a] = 8'd255;
    for (int t = 0; t < 4; t++) write_tap(t, 255);
    build_expect(4, 4);
`ifndef CONV_COPROC_SIGNED_EN
    chk("model_sat_z0", exp_data_q[0], 65025);
    chk("model_sat_z3", exp_data_q[3], 65535);
`endif
    run_op(4, 4, 1'b0, 0, 1'b0);
`ifndef CONV_COPROC_SIGNED_EN
    chk("sat_z0", got[0], 65025);
    chk("sat_z3", got[3], 65535);
`endif

    // Reset during MAC, then a run with cleared taps, then a reloaded rerun
    ymem[0] = 8'd1; ymem[1] = 8'd2; ymem[2] = 8'd3;
    for (int t = 0; t < 3; t++) write_tap(t, 1);
    run_op(3, 3, 1'b0, 8, 1'b0);
    run_op(3, 3, 1'b0, 0, 1'b0);
    chk("taps_cleared_z2", got[2], 0);
    load_basic();
    run_op(3, 3, 1'b0, 0, 1'b0);
    check_basic_got("restart_z");

`ifdef CONV_COPROC_SIGNED_EN
    ymem[0] = 8'd3; ymem[1] = 8'd4;
    write_tap(0, 8'hFF);
    write_tap(1, 8'h02);
    build_expect(2, 2);
    chk("model_signed_z0", exp_data_q[0], 16'hFFFD);
    run_op(2, 2, 1'b0, 0, 1'b0);
    chk("signed_z0", got[0], 16'hFFFD);
    chk("signed_z1", got[1], 16'h0002);
    chk("signed_z2", got[2], 16'h0008);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
